// File: rtl/alu_operand_loader.sv
// ============================================================================
// Module   : alu_operand_loader
// Brief    : Synchronises/debounces board inputs and sequences A, B, OpCode entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 4
) (
    input  logic              CLK100MHZ,
    input  logic              RST,
    input  logic [DATA_W-1:0] SW,
    input  logic              BTNC,
    input  logic              BTNU,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] OpCode,
    output logic              DispCont,
    output logic [1:0]        state,
    output logic              valid
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int              C_BTN_C    = 0;
    localparam int              C_BTN_U    = 1;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    logic [DATA_W-1:0] r_sw_meta;
    logic [DATA_W-1:0] r_sw_sync;
    logic [1:0]        r_btn_meta;
    logic [1:0]        r_btn_sync;
    logic [1:0]        w_pulse;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_op;
    logic              r_disp;
    logic              r_valid;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;
    logic [DATA_W-1:0] w_op_next;
    logic              w_disp_next;
    logic              w_valid_next;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= {BTNU, BTNC};
            r_btn_sync <= r_btn_meta;
        end
    end

    // The pulse is registered on the same edge the debounced level rises.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_pulse;

            always_ff @(posedge CLK100MHZ) begin
                if (RST) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                end else if (r_btn_sync[gi] == r_level) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_btn_sync[gi];
                    r_pulse <= r_btn_sync[gi];
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_pulse <= 1'b0;
                end
            end

            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_disp  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_disp  <= w_disp_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_valid_next = r_valid;
        w_disp_next  = r_disp ^ w_pulse[C_BTN_U];
        if (w_pulse[C_BTN_C]) begin
            case (r_state)
                S_A: begin
                    w_a_next     = r_sw_sync;
                    w_state_next = S_B;
                end
                S_B: begin
                    w_b_next     = r_sw_sync;
                    w_state_next = S_OP;
                end
                S_OP: begin
                    w_op_next    = r_sw_sync;
                    w_valid_next = 1'b1;
                    w_state_next = S_RUN;
                end
                default: begin
                    w_valid_next = 1'b0;
                    w_state_next = S_A;
                end
            endcase
        end
    end

    assign A        = r_a;
    assign B        = r_b;
    assign OpCode   = r_op;
    assign DispCont = r_disp;
    assign state    = r_state;
    assign valid    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// Module   : tb_alu_operand_loader
// Brief    : Directed self-checking bench for alu_operand_loader (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

    localparam int C_DB = 4;
    localparam int C_W  = 4;

    logic           clk;
    logic           rst;
    logic [C_W-1:0] sw;
    logic           btnc;
    logic           btnu;
    logic [C_W-1:0] a;
    logic [C_W-1:0] b;
    logic [C_W-1:0] opcode;
    logic           disp;
    logic [1:0]     st;
    logic           vld;

    int n_checks;
    int n_fail;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(C_DB),
        .DATA_W         (C_W)
    ) u_dut (
        .CLK100MHZ(clk),
        .RST      (rst),
        .SW       (sw),
        .BTNC     (btnc),
        .BTNU     (btnu),
        .A        (a),
        .B        (b),
        .OpCode   (opcode),
        .DispCont (disp),
        .state    (st),
        .valid    (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold long enough for a press pulse, then long enough for release to settle.
    task automatic press(input logic c, input logic u);
        btnc = c;
        btnu = u;
        step(10);
        btnc = 1'b0;
        btnu = 1'b0;
        step(10);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_A"},  32'(a), 32'h0);
        check({tag, "_B"},  32'(b), 32'h0);
        check({tag, "_OP"}, 32'(opcode), 32'h0);
        check({tag, "_DC"}, 32'(disp), 32'h1);
        check({tag, "_ST"}, 32'(st), 32'h0);
        check({tag, "_V"},  32'(vld), 32'h0);
    endtask

    initial begin
        logic [1:0] st_prev;
        int         n_changes;
        int         change_edge;
        logic       seen;

        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        sw   = '0;
        btnc = 1'b0;
        btnu = 1'b0;
        step(1);

        // 1. Reset
        rst = 1'b1;
        step(1);
        check_reset_vals("rst");
        step(1);
        rst = 1'b0;
        step(2);

        // 2. Full entry
        sw = 4'b1010;
        press(1'b1, 1'b0);
        check("entry_A",  32'(a), 32'hA);
        check("entry_st1", 32'(st), 32'h1);
        check("entry_v0", 32'(vld), 32'h0);
        sw = 4'b0011;
        press(1'b1, 1'b0);
        check("entry_B",  32'(b), 32'h3);
        check("entry_st2", 32'(st), 32'h2);
        sw = 4'b0000;
        press(1'b1, 1'b0);
        check("entry_OP", 32'(opcode), 32'h0);
        check("entry_st3", 32'(st), 32'h3);
        check("entry_v1", 32'(vld), 32'h1);
        sw = 4'b1111;
        press(1'b1, 1'b0);
        check("wrap_st",  32'(st), 32'h0);
        check("wrap_v",   32'(vld), 32'h0);
        check("wrap_A",   32'(a), 32'hA);
        check("wrap_B",   32'(b), 32'h3);
        check("wrap_OP",  32'(opcode), 32'h0);

        // 3. Bounce then stable high: one advance, loading A
        sw = 4'b0101;
        step(3);
        btnc = 1'b1; step(1);
        btnc = 1'b0; step(1);
        btnc = 1'b1; step(1);
        btnc = 1'b0; step(1);
        btnc = 1'b1;
        st_prev     = st;
        n_changes   = 0;
        change_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (st != st_prev) begin
                n_changes++;
                change_edge = i;
                st_prev     = st;
            end
        end
        check("bounce_changes", 32'(n_changes), 32'd1);
        check("bounce_late",    32'(change_edge >= C_DB + 2 && change_edge <= C_DB + 3), 32'd1);
        check("bounce_st",      32'(st), 32'h1);
        check("bounce_A",       32'(a), 32'h5);
        btnc = 1'b0;
        step(10);

        // 4. Glitch shorter than the debounce window
        sw = 4'b1001;
        btnc = 1'b1;
        step(3);
        btnc = 1'b0;
        step(12);
        check("glitch_st", 32'(st), 32'h1);
        check("glitch_A",  32'(a), 32'h5);

        // 5. Display toggle, second time together with BTNC
        press(1'b0, 1'b1);
        check("tog1_DC", 32'(disp), 32'h0);
        check("tog1_st", 32'(st), 32'h1);
        sw   = 4'b0110;
        btnc = 1'b1;
        btnu = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (disp !== 1'b0) seen = 1'b1;
        end
        check("tog2_seen", 32'(seen), 32'h1);
        check("tog2_DC",   32'(disp), 32'h1);
        check("tog2_st",   32'(st), 32'h2);
        check("tog2_B",    32'(b), 32'h6);
        btnc = 1'b0;
        btnu = 1'b0;
        step(10);

        // 6. Reset mid-entry, with BTNC held across reset release
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        check_reset_vals("rst2");
        sw = 4'b1010;
        press(1'b1, 1'b0);
        sw = 4'b0011;
        press(1'b1, 1'b0);
        check("mid_st", 32'(st), 32'h2);
        check("mid_B",  32'(b), 32'h3);
        btnc = 1'b1;
        sw   = 4'b1100;
        rst  = 1'b1;
        step(1);
        check_reset_vals("rst3");
        step(1);
        rst = 1'b0;
        step(12);
        check("held_st", 32'(st), 32'h1);
        check("held_A",  32'(a), 32'hC);
        check("held_B",  32'(b), 32'h0);
        btnc = 1'b0;
        step(10);
        check("held_once", 32'(st), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
